// File: rtl/register_file.sv
// register_file: MIPS architectural register file.
// 2**ADDR_WIDTH registers of DATA_WIDTH bits, two asynchronous read ports and
// one synchronous write port. Index 0 is hardwired to zero. With BYPASS=1 a
// read that hits the index being written this cycle returns write_data.
//
// Port timing: the interface has no valid/ready handshake. The read ports are
// purely combinational and are sampled by the operand latch at the end of the
// decode cycle. A write is committed on the rising edge of clk when reg_write
// is high and rst_n is high. A low rst_n on that edge clears the whole array
// and discards the write.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // A write only takes effect outside reset and never to $zero. The same
  // qualifier gates the bypass, so a reset cycle shows no bypassed data.
  logic write_en;
  assign write_en = rst_n && reg_write && (write_reg != '0);

  // Array update: synchronous clear has priority over the write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[write_reg] <= write_data;
    end
  end

  logic hit1;
  logic hit2;
  assign hit1 = BYPASS && write_en && (write_reg == read_reg1);
  assign hit2 = BYPASS && write_en && (write_reg == read_reg2);

  // Read port 1: forced zero for $zero, else bypass or stored value.
  always_comb begin
    read_data1 = '0;
    if (read_reg1 != '0) begin
      read_data1 = hit1 ? write_data : regs[read_reg1];
    end
  end

  // Read port 2: same rule as port 1.
  always_comb begin
    read_data2 = '0;
    if (read_reg2 != '0) begin
      read_data2 = hit2 ? write_data : regs[read_reg2];
    end
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural register file of the multi-cycle MIPS datapath: 32 general-purpose registers, two asynchronous read ports, one synchronous write port. Sits directly upstream of the A/B operand latch stage. The decoded rs/rt fields address the read ports. The write-back mux (ALUOut or memory data register, destination rt/rd/$ra) drives the write port. Register $zero is hardwired to zero; an optional write-to-read bypass lets a register written in a cycle be read the same cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH registers)
- BYPASS, 1, 1 = read port returns write_data when a same-cycle write targets the read index; 0 = read returns stored value only

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- read_reg1  input  ADDR_WIDTH  read port 1 index (instruction rs)
- read_reg2  input  ADDR_WIDTH  read port 2 index (instruction rt)
- write_reg  input  ADDR_WIDTH  write port index (selected rt/rd/31)
- write_data  input  DATA_WIDTH  write-back value
- reg_write  input  1  write enable from control FSM
- read_data1  output  DATA_WIDTH  read port 1 value, feeds A latch
- read_data2  output  DATA_WIDTH  read port 2 value, feeds B latch

## Operation
- Storage: array regs[0..2**ADDR_WIDTH-1] of DATA_WIDTH bits.
- Reset: rising edge with rst_n=0 clears every register to 0. Reset overrides reg_write: no write occurs in a reset cycle.
- Write: rising edge with rst_n=1, reg_write=1 and write_reg!=0 loads regs[write_reg] <= write_data. All other registers hold.
- Writes to index 0 are discarded. regs[0] stays 0 permanently.
- Read, BYPASS=0: read_dataN = (read_regN==0) ? 0 : regs[read_regN]. Purely combinational.
- Read, BYPASS=1: if reg_write=1, rst_n=1, write_reg==read_regN and read_regN!=0, then read_dataN = write_data. Otherwise the BYPASS=0 rule applies.
- Both ports may address the same register; both return the identical value.
- Both ports may match the write index; both are bypassed.
- Out-of-range indices cannot occur; the array size is exactly 2**ADDR_WIDTH.
- No X propagation: all registers are defined after the first reset edge.

## Timing
- Read latency: 0 cycles, combinational from read_regN and the array (and from write_data/reg_write/write_reg when BYPASS=1).
- Write latency: 1 edge. The value is visible through the array read path after the rising edge that commits it.
- Reset output values:
  - During reset assertion before the edge, the outputs reflect the prior array contents.
  - After the first rising edge with rst_n=0, read_data1 = read_data2 = 0 for every index.
  - After reset, the outputs remain 0 until a write commits.
- Reset mid-operation: rst_n=0 coinciding with reg_write=1 means reset wins. The target register reads 0 afterwards, and the bypass is suppressed in that cycle.
- rst_n released: the first write can commit on the same edge at which rst_n is sampled high.
- Consumer contract: the downstream operand latch samples read_data1/2 at the end of the decode cycle. The outputs must be settled within one clk period of a read_reg change.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to r5, then hold rst_n=0 for 1 edge, then read r5 and r31.
  - Required response: read_data1 = read_data2 = 0x00000000.
- Basic write/read:
  - Stimulus: write 0x12345678 to r8 and 0xCAFEF00D to r9, then set read_reg1=8 and read_reg2=9.
  - Required response: 0x12345678 and 0xCAFEF00D.
  - Also: r10 still reads 0.
- $zero protection:
  - Stimulus: reg_write=1, write_reg=0, write_data=0xFFFFFFFF, then read_reg1=read_reg2=0.
  - Required response: both outputs read 0, both on the same cycle and after the edge.
- Bypass:
  - Stimulus, BYPASS=1: r3 holds 0x11111111. In one cycle set reg_write=1, write_reg=3, write_data=0x22222222, read_reg1=3, read_reg2=3.
  - Required response, same cycle: both outputs read 0x22222222.
  - Stimulus, BYPASS=0: repeat the same cycle.
  - Required response: both outputs read 0x11111111 before the edge and 0x22222222 after it.
- Reset vs write:
  - Stimulus: rst_n=0 with reg_write=1, write_reg=7, write_data=0xA5A5A5A5.
  - Required response: r7 reads 0 after the edge, and no bypass is visible during that cycle.
- Full sweep:
  - Stimulus: write value 0x100+i to ri for i=1..31, then read all 32 indices on both ports.
  - Required response: ri returns 0x100+i on both ports, and r0 returns 0.
